// File: rtl/trc_cfg_pkg.sv
// Shared constants and FSM state type for the transceiver-reconfig configuration sequencer.
package trc_cfg_pkg;

  localparam logic [6:0] PMA_CH_NR  = 7'h08;
  localparam logic [6:0] PMA_STATUS = 7'h0A;
  localparam logic [6:0] PMA_OFFSET = 7'h0B;
  localparam logic [6:0] PMA_DATA   = 7'h0C;

  localparam int BUSY_BIT  = 8;
  localparam int ERROR_BIT = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_CHECK,
    ST_NEXT,
    ST_DONE,
    ST_FAIL
  } cfg_state_t;

endpackage

// File: rtl/trc_config_sequencer.sv
// Walks the reconfig LUT and turns each entry into one Avalon-MM write, or into
// PMA_STATUS poll reads that repeat until the busy bit clears.
module trc_config_sequencer #(
  parameter int LUT_LENGTH   = 19,
  parameter int BUSY_BIT     = trc_cfg_pkg::BUSY_BIT,
  parameter int ERROR_BIT    = trc_cfg_pkg::ERROR_BIT,
  parameter int POLL_TIMEOUT = 65535,
  parameter bit AUTO_START   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic [5:0]              lut_index,
  input  logic [7:0]              lut_address,
  input  logic [31:0]             lut_data,
  input  logic                    lut_wr,
  output logic [6:0]              mgmt_address,
  output logic [31:0]             mgmt_writedata,
  output logic                    mgmt_write,
  output logic                    mgmt_read,
  input  logic [31:0]             mgmt_readdata,
  input  logic                    mgmt_waitrequest,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output trc_cfg_pkg::cfg_state_t state_dbg
);
  import trc_cfg_pkg::*;

  localparam logic [5:0]  LAST_INDEX = 6'(LUT_LENGTH - 1);
  localparam logic [15:0] POLL_MAX   = 16'(POLL_TIMEOUT);

  cfg_state_t  state;
  logic        wr_q;
  logic [15:0] poll_cnt;
  logic        rd_busy;
  logic        rd_err;
  logic        unused_inputs;

  assign state_dbg     = state;
  assign unused_inputs = ^{lut_address[7], mgmt_readdata};

  // Handshake: a strobe (mgmt_write or mgmt_read) is a request; it is accepted on the
  // clock edge where mgmt_waitrequest is low. Until then strobe, address and data hold,
  // and only one request is ever outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      lut_index      <= '0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
      mgmt_write     <= 1'b0;
      mgmt_read      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      wr_q           <= 1'b0;
      poll_cnt       <= '0;
      rd_busy        <= 1'b0;
      rd_err         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start || AUTO_START) begin
            state     <= ST_LOAD;
            lut_index <= '0;
            busy      <= 1'b1;
          end
        end
        // The LUT has had this whole cycle to settle on the new index.
        ST_LOAD: begin
          mgmt_address   <= lut_address[6:0];
          mgmt_writedata <= lut_data;
          wr_q           <= lut_wr;
          mgmt_write     <= lut_wr;
          mgmt_read      <= !lut_wr;
          poll_cnt       <= '0;
          state          <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (!mgmt_waitrequest) begin
            mgmt_write <= 1'b0;
            mgmt_read  <= 1'b0;
            if (wr_q) begin
              state <= ST_NEXT;
            end else begin
              rd_busy <= mgmt_readdata[BUSY_BIT];
              rd_err  <= mgmt_readdata[ERROR_BIT];
              state   <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (rd_err) error <= 1'b1;
          if (rd_busy) begin
            if (poll_cnt < POLL_MAX) begin
              poll_cnt  <= poll_cnt + 16'd1;
              mgmt_read <= 1'b1;
              state     <= ST_ISSUE;
            end else begin
              error <= 1'b1;
              done  <= 1'b0;
              busy  <= 1'b0;
              state <= ST_FAIL;
            end
          end else begin
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (lut_index == LAST_INDEX) begin
            busy  <= 1'b0;
            done  <= !error;
            state <= ST_DONE;
          end else begin
            lut_index <= lut_index + 6'd1;
            state     <= ST_LOAD;
          end
        end
        ST_DONE, ST_FAIL: begin
          if (start) begin
            lut_index <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            state     <= ST_LOAD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
